// File: rtl/rob_ar_arbiter_if.sv
// Requester-side and reorder-buffer-side AR/R signals of the arbiter.
// master = arbiter view, slave = environment (requesters plus reorder buffer) view.
interface rob_ar_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int LID_W = 4 - IDX_W;

    logic [NUM_REQ*LID_W-1:0]      req_arid_i;
    logic [NUM_REQ-1:0]            req_arvalid_i;
    logic [NUM_REQ-1:0]            req_arready_o;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_rdata_o;
    logic [NUM_REQ*LID_W-1:0]      req_rid_o;
    logic [NUM_REQ-1:0]            req_rvalid_o;
    logic [NUM_REQ-1:0]            req_rready_i;
    logic [3:0]                    m_arid_o;
    logic                          m_arvalid_o;
    logic                          m_arready_i;
    logic [DATA_WIDTH-1:0]         m_rdata_i;
    logic [3:0]                    m_rid_i;
    logic                          m_rvalid_i;
    logic                          m_rready_o;

    modport master (
        input  req_arid_i, req_arvalid_i, req_rready_i,
        input  m_arready_i, m_rdata_i, m_rid_i, m_rvalid_i,
        output req_arready_o, req_rdata_o, req_rid_o, req_rvalid_o,
        output m_arid_o, m_arvalid_o, m_rready_o
    );

    modport slave (
        output req_arid_i, req_arvalid_i, req_rready_i,
        output m_arready_i, m_rdata_i, m_rid_i, m_rvalid_i,
        input  req_arready_o, req_rdata_o, req_rid_o, req_rvalid_o,
        input  m_arid_o, m_arvalid_o, m_rready_o
    );
endinterface

// File: rtl/rob_ar_arbiter.sv
// Round-robin AR arbiter in front of a reorder buffer: tags ARID with requester index,
// caps outstanding reads per requester, and steers R beats back by the ID tag (zero latency).
module rob_ar_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic             clk,
    input  logic             rst,
    rob_ar_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int LID_W = 4 - IDX_W;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]         arid_q, arid_d;
    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rvalid;
    logic [NUM_REQ-1:0] r_hs;
    logic [IDX_W-1:0]   ridx;
    logic [IDX_W-1:0]   ptr_eff;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   idx;
    logic               ar_hs;
    logic               found;
    logic               accept;

    // R path: purely combinational steering by the index bits of the returned ID
    assign ridx = bus.m_rid_i[3:LID_W];

    always_comb begin
        rvalid       = '0;
        rvalid[ridx] = bus.m_rvalid_i;
    end

    assign r_hs             = rvalid & bus.req_rready_i;
    assign bus.req_rvalid_o = rvalid;
    assign bus.m_rready_o   = bus.req_rready_i[ridx];
    assign bus.req_rdata_o  = {NUM_REQ{bus.m_rdata_i}};
    assign bus.req_rid_o    = {NUM_REQ{bus.m_rid_i[LID_W-1:0]}};

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            eligible[r] = bus.req_arvalid_i[r] && (cnt_q[r] < CNT_W'(MAX_OUTST));
        end
    end

    // On a handshake the pointer advance is visible to the pick in the same cycle
    assign ar_hs   = (state_q == BUSY) && bus.m_arready_i;
    assign ptr_eff = ar_hs ? (arid_q[3:LID_W] + 1'b1) : rr_ptr_q;

    always_comb begin
        found = 1'b0;
        pick  = ptr_eff;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr_eff + IDX_W'(i);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign accept = found && ((state_q == IDLE) || ar_hs) && !rst;
    assign grant  = accept ? (NUM_REQ'(1) << pick) : '0;

    assign bus.req_arready_o = grant;
    assign bus.m_arvalid_o   = (state_q == BUSY);
    assign bus.m_arid_o      = arid_q;

    always_comb begin
        state_d  = state_q;
        arid_d   = arid_q;
        rr_ptr_d = ar_hs ? ptr_eff : rr_ptr_q;
        if (accept) begin
            state_d = BUSY;
            arid_d  = {pick, bus.req_arid_i[pick*LID_W +: LID_W]};
        end else if (ar_hs) begin
            state_d = IDLE;
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            cnt_d[r] = cnt_q[r] + CNT_W'(grant[r]) - CNT_W'(r_hs[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            arid_q   <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            arid_q   <= arid_d;
            for (int r = 0; r < NUM_REQ; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end
endmodule

// File: tb/tb_rob_ar_arbiter.sv
// Directed bench for rob_ar_arbiter with a cycle-level reference model checked every negedge.
module tb_rob_ar_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rob_ar_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

    rob_ar_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_OUTST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending AR, outstanding counts and round-robin start index
    int         m_cnt [4];
    int         m_ptr;
    int         m_gidx;
    bit         m_busy;
    logic [3:0] m_id;

    function automatic void decide(output bit acc, output int p, output bit hs);
        int ptr;
        hs  = m_busy && bus.m_arready_i;
        ptr = hs ? (m_gidx + 1) % 4 : m_ptr;
        acc = 1'b0;
        p   = 0;
        if (!m_busy || hs) begin
            for (int k = 0; k < 4; k++) begin
                int r;
                r = (ptr + k) % 4;
                if (!acc && bus.req_arvalid_i[r] && m_cnt[r] < 4) begin
                    acc = 1'b1;
                    p   = r;
                end
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit acc, hs;
        int p, ri;
        if (rst) begin
            for (int r = 0; r < 4; r++) m_cnt[r] = 0;
            m_ptr  = 0;
            m_gidx = 0;
            m_busy = 1'b0;
            m_id   = 4'h0;
        end else begin
            decide(acc, p, hs);
            ri = int'(bus.m_rid_i) / 4;
            if (bus.m_rvalid_i && bus.req_rready_i[ri]) m_cnt[ri] = m_cnt[ri] - 1;
            if (hs) m_ptr = (m_gidx + 1) % 4;
            if (acc) begin
                m_cnt[p] = m_cnt[p] + 1;
                m_busy   = 1'b1;
                m_gidx   = p;
                m_id     = 4'((p << 2) | int'(bus.req_arid_i[p*2 +: 2]));
            end else if (hs) begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit acc, hs;
        int p, ri;
        decide(acc, p, hs);
        if (rst) acc = 1'b0;
        ri = int'(bus.m_rid_i) / 4;
        chk("m_arready", 32'(bus.req_arready_o), acc ? (32'd1 << p) : 32'd0);
        chk("m_arvalid", 32'(bus.m_arvalid_o), 32'(m_busy));
        chk("m_arid", 32'(bus.m_arid_o), 32'(m_id));
        chk("m_rvalid", 32'(bus.req_rvalid_o), bus.m_rvalid_i ? (32'd1 << ri) : 32'd0);
        chk("m_rready", 32'(bus.m_rready_o), 32'(bus.req_rready_i[ri]));
        chk("m_rdata", bus.req_rdata_o, {4{bus.m_rdata_i}});
        chk("m_rid", 32'(bus.req_rid_o), 32'({4{bus.m_rid_i[1:0]}}));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_arid_i    = '0;
        bus.req_arvalid_i = '0;
        bus.req_rready_i  = '0;
        bus.m_arready_i   = 1'b0;
        bus.m_rdata_i     = '0;
        bus.m_rid_i       = '0;
        bus.m_rvalid_i    = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        clear_inputs();
        bus.req_arvalid_i = 4'hF;
        #2;
        chk("rst_arvalid", 32'(bus.m_arvalid_o), 32'd0);
        chk("rst_arid", 32'(bus.m_arid_o), 32'd0);
        chk("rst_arready", 32'(bus.req_arready_o), 32'd0);
        tick();
        bus.req_arvalid_i = 4'h0;
        rst = 1'b0;

        // single request, one-cycle AR latency
        bus.req_arid_i    = 8'h02;
        bus.req_arvalid_i = 4'b0001;
        #1 chk("t1_arready", 32'(bus.req_arready_o), 32'h1);
        tick();
        bus.req_arvalid_i = 4'b0000;
        #1 chk("t1_arvalid", 32'(bus.m_arvalid_o), 32'd1);
        chk("t1_arid", 32'(bus.m_arid_o), 32'h2);
        bus.m_arready_i = 1'b1;
        tick();
        bus.m_arready_i = 1'b0;
        #1 chk("t1_idle", 32'(bus.m_arvalid_o), 32'd0);
        do_reset();

        // all requesting, back-to-back round robin
        bus.req_arid_i    = 8'b11_10_01_00;
        bus.req_arvalid_i = 4'hF;
        bus.m_arready_i   = 1'b1;
        #1 chk("t2_first", 32'(bus.req_arready_o), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            #1 chk("t2_arid_idx", 32'(bus.m_arid_o[3:2]), 32'(k % 4));
            chk("t2_grant", 32'(bus.req_arready_o), 32'd1 << ((k + 1) % 4));
        end
        do_reset();

        // outstanding limit on requester 1
        bus.req_arid_i    = 8'b00_00_11_00;
        bus.req_arvalid_i = 4'b0010;
        bus.m_arready_i   = 1'b1;
        #1 chk("t3_g1", 32'(bus.req_arready_o), 32'h2);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1 chk("t3_gn", 32'(bus.req_arready_o), 32'h2);
            chk("t3_arid", 32'(bus.m_arid_o), 32'h7);
        end
        tick();
        #1 chk("t3_block", 32'(bus.req_arready_o), 32'h0);
        tick();
        #1 chk("t3_idle", 32'(bus.m_arvalid_o), 32'd0);
        chk("t3_block2", 32'(bus.req_arready_o), 32'h0);
        bus.m_rvalid_i   = 1'b1;
        bus.m_rid_i      = 4'h5;
        bus.m_rdata_i    = 8'h3C;
        bus.req_rready_i = 4'b0010;
        #1 chk("t3_rready", 32'(bus.m_rready_o), 32'd1);
        chk("t3_rvalid", 32'(bus.req_rvalid_o), 32'h2);
        tick();
        bus.m_rvalid_i   = 1'b0;
        bus.req_rready_i = 4'b0000;
        #1 chk("t3_fifth", 32'(bus.req_arready_o), 32'h2);
        do_reset();

        // stall with m_arready low
        bus.req_arid_i    = 8'b00_10_00_01;
        bus.req_arvalid_i = 4'b0101;
        #1 chk("t4_g0", 32'(bus.req_arready_o), 32'h1);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1 chk("t4_hold_vld", 32'(bus.m_arvalid_o), 32'd1);
            chk("t4_hold_id", 32'(bus.m_arid_o), 32'h1);
            chk("t4_hold_rdy", 32'(bus.req_arready_o), 32'h0);
            tick();
        end
        bus.m_arready_i = 1'b1;
        #1 chk("t4_g2", 32'(bus.req_arready_o), 32'h4);
        tick();
        bus.req_arvalid_i = 4'b0000;
        #1 chk("t4_arid2", 32'(bus.m_arid_o), 32'hA);
        tick();
        bus.m_arready_i = 1'b0;

        // R routing to requester 2 with backpressure
        bus.m_rvalid_i   = 1'b1;
        bus.m_rid_i      = 4'hB;
        bus.m_rdata_i    = 8'hA5;
        bus.req_rready_i = 4'b0000;
        #1 chk("t5_rvalid", 32'(bus.req_rvalid_o), 32'h4);
        chk("t5_rready0", 32'(bus.m_rready_o), 32'd0);
        chk("t5_rdata", bus.req_rdata_o, 32'hA5A5A5A5);
        chk("t5_rid_all", 32'(bus.req_rid_o), 32'hFF);
        tick();
        bus.req_rready_i = 4'b0100;
        #1 chk("t5_rready1", 32'(bus.m_rready_o), 32'd1);
        chk("t5_rid2", 32'(bus.req_rid_o[5:4]), 32'd3);
        tick();
        bus.m_rvalid_i    = 1'b0;
        bus.req_rready_i  = 4'b0000;
        bus.req_arvalid_i = 4'b0100;
        bus.m_arready_i   = 1'b1;
        #1 chk("t5_cnt_a", 32'(bus.req_arready_o), 32'h4);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1 chk("t5_cnt_b", 32'(bus.req_arready_o), 32'h4);
        end
        tick();
        #1 chk("t5_cnt_full", 32'(bus.req_arready_o), 32'h0);
        do_reset();

        // simultaneous accept and R for requester 3, then reset while busy
        bus.req_arid_i    = 8'b01_00_00_00;
        bus.req_arvalid_i = 4'b1000;
        #1 chk("t6_g3", 32'(bus.req_arready_o), 32'h8);
        tick();
        bus.m_arready_i  = 1'b1;
        bus.m_rvalid_i   = 1'b1;
        bus.m_rid_i      = 4'hD;
        bus.req_rready_i = 4'b1000;
        #1 chk("t6_both_ar", 32'(bus.req_arready_o), 32'h8);
        chk("t6_both_r", 32'(bus.m_rready_o), 32'd1);
        tick();
        bus.m_rvalid_i   = 1'b0;
        bus.req_rready_i = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t6_more", 32'(bus.req_arready_o), 32'h8);
            tick();
        end
        #1 chk("t6_full", 32'(bus.req_arready_o), 32'h0);
        bus.m_arready_i = 1'b0;
        #1 chk("t6_busy", 32'(bus.m_arvalid_o), 32'd1);
        rst = 1'b1;
        #1 chk("t6_rst_vld", 32'(bus.m_arvalid_o), 32'd0);
        chk("t6_rst_id", 32'(bus.m_arid_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
